// File: rtl/serv_dbus_ram.sv
// serv_dbus_ram: wishbone data-bus responder backed by a byte-lane RAM with configurable wait states
module serv_dbus_ram #(
  parameter int DEPTH          = 256,
  parameter int WAIT_STATES    = 0,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack
);
  localparam int AW = $clog2(DEPTH);
  localparam bit RST_ALL = RESET_STRATEGY == "ALL";
  typedef enum logic [1:0] {IDLE, WAIT, ACK, GAP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [AW-3:0] idx, rd_idx;
  logic we, rd_we;
  logic [3:0] sel;
  logic [31:0] dat;
  logic [31:0] mem [DEPTH/4];
  logic unused_adr;
  assign unused_adr = ^{i_wb_adr[31:AW], i_wb_adr[1:0]};
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (i_wb_cyc) begin
        state_n = WAIT_STATES == 0 ? ACK : WAIT;
        cnt_n = 4'(WAIT_STATES);
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        state_n = !i_wb_cyc ? IDLE : cnt == 4'd1 ? ACK : WAIT;
      end
      ACK: state_n = GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      o_wb_ack <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      o_wb_ack <= state_n == ACK;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst && state == IDLE && i_wb_cyc) begin
      idx <= i_wb_adr[AW-1:2];
      we <= i_wb_we;
      sel <= i_wb_sel;
      dat <= i_wb_dat;
    end
  end
  // With zero wait states the read is issued straight from the bus inputs
  assign rd_idx = state == IDLE ? i_wb_adr[AW-1:2] : idx;
  assign rd_we = state == IDLE ? i_wb_we : we;
  always_ff @(posedge i_clk) begin
    if (i_rst && RST_ALL)
      o_wb_rdt <= 32'd0;
    else if (!i_rst && state_n == ACK && !rd_we)
      o_wb_rdt <= mem[rd_idx];
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst && state == ACK && we)
      for (int i = 0; i < 4; i++)
        if (sel[i]) mem[idx][8*i+:8] <= dat[8*i+:8];
  end
endmodule

// File: tb/tb_serv_dbus_ram.sv
// tb_serv_dbus_ram: directed checks of a zero-wait MINI instance and a three-wait ALL instance
module tb_serv_dbus_ram;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [2], cyc [2], we [2], ack [2];
  logic [31:0] adr [2], dat [2], rdt [2];
  logic [3:0] sel [2];
  int total = 0, bad = 0;
  int lat, na, first, second;

  serv_dbus_ram #(.DEPTH(256), .WAIT_STATES(0), .RESET_STRATEGY("MINI")) u0 (
    .i_clk(clk), .i_rst(rst[0]), .i_wb_adr(adr[0]), .i_wb_dat(dat[0]), .i_wb_sel(sel[0]),
    .i_wb_we(we[0]), .i_wb_cyc(cyc[0]), .o_wb_rdt(rdt[0]), .o_wb_ack(ack[0]));
  serv_dbus_ram #(.DEPTH(256), .WAIT_STATES(3), .RESET_STRATEGY("ALL")) u1 (
    .i_clk(clk), .i_rst(rst[1]), .i_wb_adr(adr[1]), .i_wb_dat(dat[1]), .i_wb_sel(sel[1]),
    .i_wb_we(we[1]), .i_wb_cyc(cyc[1]), .o_wb_rdt(rdt[1]), .o_wb_ack(ack[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold cyc until ack (bounded), scramble inputs after capture, then count acks while idle
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] dt,
                      input logic [3:0] s, output int l, output int n_ack);
    l = -1;
    n_ack = 0;
    cyc[d] = 1'b1; we[d] = w; adr[d] = a; dat[d] = dt; sel[d] = s;
    for (int n = 1; n <= 40 && l < 0; n++) begin
      tick();
      if (ack[d]) begin l = n; n_ack = 1; end
      if (n == 1) begin adr[d] = ~a; dat[d] = ~dt; sel[d] = ~s; end
    end
    cyc[d] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      if (ack[d]) n_ack++;
    end
  endtask

  task automatic count_acks(input int d, input int cycles, output int n_ack);
    n_ack = 0;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (ack[d]) n_ack++;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b0; we[d] = 1'b0; adr[d] = '0; dat[d] = '0; sel[d] = '0;
    end
    tick();
    tick();
    chk("reset_ack0", 32'(ack[0]), 32'd0);
    chk("reset_ack1", 32'(ack[1]), 32'd0);
    chk("reset_rdt_all", rdt[1], 32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();

    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, na);
    chk("w0_latency", 32'(lat), 32'd1);
    chk("w0_single_ack", 32'(na), 32'd1);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, na);
    chk("r0_latency", 32'(lat), 32'd1);
    chk("r0_single_ack", 32'(na), 32'd1);
    chk("r0_data", rdt[0], 32'hDEADBEEF);

    xfer(0, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, na);
    xfer(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, na);
    chk("rdt_hold_over_writes", rdt[0], 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, lat, na);
    chk("byte_lanes", rdt[0], 32'h11BB33DD);

    xfer(0, 1'b1, 32'h0, 32'h5A5A5A5A, 4'hF, lat, na);
    xfer(0, 1'b0, 32'h103, 32'h0, 4'h0, lat, na);
    chk("alias_read", rdt[0], 32'h5A5A5A5A);

    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("mini_rdt_kept", rdt[0], 32'h5A5A5A5A);
    chk("mini_reset_ack", 32'(ack[0]), 32'd0);

    rst[0] = 1'b1; cyc[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h10; dat[0] = 32'h0; sel[0] = 4'hF;
    tick();
    rst[0] = 1'b0; cyc[0] = 1'b0;
    count_acks(0, 4, na);
    chk("rst_cyc_no_ack", 32'(na), 32'd0);
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, na);
    chk("rst_cyc_no_write", rdt[0], 32'hDEADBEEF);

    xfer(1, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, lat, na);
    chk("ws3_latency", 32'(lat), 32'd4);
    chk("ws3_single_ack", 32'(na), 32'd1);

    // cyc stays high through ack and GAP: the follow-up must be taken in the next IDLE
    first = -1;
    second = -1;
    cyc[1] = 1'b1; we[1] = 1'b0; adr[1] = 32'h40;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (ack[1]) begin
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
    end
    cyc[1] = 1'b0;
    tick();
    tick();
    chk("gap_first_ack", 32'(first), 32'd4);
    chk("gap_second_ack", 32'(second), 32'd10);
    chk("ws3_read_data", rdt[1], 32'hCAFEF00D);

    xfer(1, 1'b1, 32'h30, 32'h01020304, 4'hF, lat, na);
    cyc[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h30; dat[1] = 32'hFFFFFFFF; sel[1] = 4'hF;
    tick();
    tick();
    cyc[1] = 1'b0;
    count_acks(1, 6, na);
    chk("abort_no_ack", 32'(na), 32'd0);
    xfer(1, 1'b0, 32'h30, 32'h0, 4'h0, lat, na);
    chk("abort_read_latency", 32'(lat), 32'd4);
    chk("abort_old_data", rdt[1], 32'h01020304);

    xfer(1, 1'b1, 32'h50, 32'h13572468, 4'hF, lat, na);
    xfer(1, 1'b0, 32'h50, 32'h0, 4'h0, lat, na);
    chk("pre_reset_read", rdt[1], 32'h13572468);
    cyc[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h50; dat[1] = 32'h0; sel[1] = 4'hF;
    tick();
    tick();
    rst[1] = 1'b1;
    cyc[1] = 1'b0;
    tick();
    chk("midwrite_reset_ack", 32'(ack[1]), 32'd0);
    chk("midwrite_reset_rdt", rdt[1], 32'd0);
    rst[1] = 1'b0;
    count_acks(1, 6, na);
    chk("midwrite_no_ack", 32'(na), 32'd0);
    xfer(1, 1'b0, 32'h50, 32'h0, 4'h0, lat, na);
    chk("midwrite_word_kept", rdt[1], 32'h13572468);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
